// File: rtl/imem_pkg.sv
`default_nettype none
// imem_pkg: loader FSM encodings, status flag bundle and the shared memory depth.
// Also imported by the instruction memory so both agree on MEM_SIZE.
package imem_pkg;

  localparam int unsigned MEM_SIZE_DEFAULT = 17;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    CSUM  = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

  typedef struct packed {
    logic ready;
    logic busy;
    logic done;
    logic error;
  } flags_t;

  // Status flags that hold while the FSM sits in state s; loaded together with the state.
  function automatic flags_t flags_of(state_t s);
    flags_t f;
    f = '0;
    case (s)
      LEN, DATA, CSUM: begin
        f.ready = 1'b1;
        f.busy  = 1'b1;
      end
      WRITE:   f.busy  = 1'b1;
      DONE:    f.done  = 1'b1;
      ERR:     f.error = 1'b1;
      default: f = '0;
    endcase
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// imem_loader_if: byte stream in, instruction-memory write port and status out.
interface imem_loader_if;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, wr_en, wr_addr, wr_data, busy, done, error
  );

  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, wr_en, wr_addr, wr_data, busy, done, error
  );
endinterface
`default_nettype wire

// File: rtl/word_assembler.sv
`default_nettype none
// word_assembler: little-endian byte packing into a 32-bit word plus running XOR checksum.
module word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        xor_en,
  input  logic        pack_en,
  input  logic [1:0]  lane,
  input  logic [7:0]  data,
  output logic [31:0] word_next,
  output logic [7:0]  csum
);

  logic [31:0] word;

  // Word with the current byte merged, so the loader can capture it on the same edge.
  always_comb begin
    word_next = word;
    word_next[{lane, 3'b000} +: 8] = data;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      word <= '0;
      csum <= '0;
    end else begin
      if (pack_en) word <= word_next;
      if (xor_en)  csum <= csum ^ data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// imem_loader: length-prefixed, XOR-checked byte stream loader for instruction memory.
module imem_loader
  import imem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'b0,
  parameter int unsigned MEM_SIZE  = MEM_SIZE_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  imem_loader_if.slave bus
);

  state_t      state;
  flags_t      flags;
  logic [7:0]  word_count;
  logic [7:0]  word_idx;
  logic [1:0]  byte_idx;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  logic        accept;
  logic        asm_clear;
  logic        xor_en;
  logic        pack_en;
  logic [31:0] word_next;
  logic [7:0]  csum;

  assign accept    = bus.byte_valid && flags.ready;
  assign asm_clear = bus.start && (state == IDLE || state == DONE || state == ERR);
  assign xor_en    = accept && (state == LEN || state == DATA);
  assign pack_en   = accept && (state == DATA);

  word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (asm_clear),
    .xor_en    (xor_en),
    .pack_en   (pack_en),
    .lane      (byte_idx),
    .data      (bus.byte_data),
    .word_next (word_next),
    .csum      (csum)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      flags      <= '0;
      word_count <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (bus.start) begin
            state    <= LEN;
            flags    <= flags_of(LEN);
            word_idx <= '0;
            byte_idx <= '0;
          end
        end
        LEN: begin
          if (accept) begin
            word_count <= bus.byte_data;
            if (bus.byte_data == 8'd0 || {24'd0, bus.byte_data} > MEM_SIZE) begin
              state <= ERR;
              flags <= flags_of(ERR);
            end else begin
              state <= DATA;
              flags <= flags_of(DATA);
            end
          end
        end
        DATA: begin
          if (accept) begin
            byte_idx <= byte_idx + 2'd1;
            // Fourth byte: launch the write on this edge so wr_en follows one cycle later.
            if (byte_idx == 2'd3) begin
              state   <= WRITE;
              flags   <= flags_of(WRITE);
              wr_en   <= 1'b1;
              wr_data <= word_next;
              wr_addr <= BASE_ADDR + {24'd0, word_idx};
            end
          end
        end
        WRITE: begin
          word_idx <= word_idx + 8'd1;
          if ((word_idx + 8'd1) == word_count) begin
            state <= CSUM;
            flags <= flags_of(CSUM);
          end else begin
            state <= DATA;
            flags <= flags_of(DATA);
          end
        end
        CSUM: begin
          if (accept) begin
            if (bus.byte_data == csum) begin
              state <= DONE;
              flags <= flags_of(DONE);
            end else begin
              state <= ERR;
              flags <= flags_of(ERR);
            end
          end
        end
        default: begin
          state <= IDLE;
          flags <= flags_of(IDLE);
        end
      endcase
    end
  end

  assign bus.byte_ready = flags.ready;
  assign bus.busy       = flags.busy;
  assign bus.done       = flags.done;
  assign bus.error      = flags.error;
  assign bus.wr_en      = wr_en;
  assign bus.wr_addr    = wr_addr;
  assign bus.wr_data    = wr_data;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// tb_imem_loader: directed scenarios on two loaders (BASE_ADDR 0 and 0x10) fed the same stream.
module tb_imem_loader;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  imem_loader_if bus0();
  imem_loader_if bus1();

  imem_loader #(.BASE_ADDR(32'h0), .MEM_SIZE(17)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  imem_loader #(.BASE_ADDR(32'h10), .MEM_SIZE(17)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  assign bus1.start      = bus0.start;
  assign bus1.byte_valid = bus0.byte_valid;
  assign bus1.byte_data  = bus0.byte_data;

  always #5 clk = ~clk;

  logic [31:0] a0_q[$];
  logic [31:0] d0_q[$];
  logic [31:0] a1_q[$];
  int ready_in_wr = 0;
  int wr_outside  = 0;

  always @(negedge clk) begin
    if (bus0.wr_en === 1'b1) begin
      a0_q.push_back(bus0.wr_addr);
      d0_q.push_back(bus0.wr_data);
      if (bus0.byte_ready !== 1'b0) ready_in_wr++;
      if (bus0.busy !== 1'b1) wr_outside++;
    end
    if (bus1.wr_en === 1'b1) a1_q.push_back(bus1.wr_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    a0_q.delete();
    d0_q.delete();
    a1_q.delete();
  endtask

  task automatic pulse_start();
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the byte.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus0.byte_valid = 1'b1;
    bus0.byte_data  = b;
    @(negedge clk);
    while (bus0.byte_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus0.byte_ready !== 1'b1) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_byte_timeout: byte_ready=%b required 1 for byte %h", bus0.byte_ready, b);
    end
    tick();
    bus0.byte_valid = 1'b0;
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    @(negedge clk);
    while (!(bus0.done === 1'b1 || bus0.error === 1'b1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!(bus0.done === 1'b1 || bus0.error === 1'b1)) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_end_timeout: done=%b error=%b required one of them 1", bus0.done, bus0.error);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    n_cmp++;
    if ({bus0.byte_ready, bus0.wr_en, bus0.busy, bus0.done, bus0.error} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: ready/wr_en/busy/done/error=%b required 00000",
               {bus0.byte_ready, bus0.wr_en, bus0.busy, bus0.done, bus0.error});
    end
    n_cmp++;
    if (bus0.wr_addr !== 32'h0 || bus0.wr_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_bus: wr_addr=%h wr_data=%h required 0 0", bus0.wr_addr, bus0.wr_data);
    end
    n_cmp++;
    if (bus1.wr_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_addr_base: wr_addr=%h required 00000000", bus1.wr_addr);
    end
    tick();
    reset = 1'b0;
  endtask

  // Checksum 02^20^04^01^8C = AB.
  task automatic test_two_words();
    clear_log();
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h20); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    @(negedge clk);
    n_cmp++;
    if (bus0.wr_en !== 1'b1 || bus0.wr_data !== 32'h0000_0020 || bus0.byte_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL write_latency: wr_en=%b wr_data=%h ready=%b required 1 00000020 0",
               bus0.wr_en, bus0.wr_data, bus0.byte_ready);
    end
    tick();
    send_byte(8'h04); send_byte(8'h00); send_byte(8'h01); send_byte(8'h8C);
    send_byte(8'hAB);
    wait_end();
    n_cmp++;
    if (a0_q.size() !== 2) begin
      n_fail++;
      $display("FAIL two_words_count: writes=%0d required 2", a0_q.size());
    end else begin
      n_cmp++;
      if (a0_q[0] !== 32'h0 || a0_q[1] !== 32'h1) begin
        n_fail++;
        $display("FAIL two_words_addr: addr=%h,%h required 0,1", a0_q[0], a0_q[1]);
      end
      n_cmp++;
      if (d0_q[0] !== 32'h0000_0020 || d0_q[1] !== 32'h8C01_0004) begin
        n_fail++;
        $display("FAIL two_words_data: data=%h,%h required 00000020,8c010004", d0_q[0], d0_q[1]);
      end
    end
    n_cmp++;
    if (bus0.done !== 1'b1 || bus0.error !== 1'b0 || bus0.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL two_words_done: done=%b error=%b busy=%b required 1 0 0",
               bus0.done, bus0.error, bus0.busy);
    end
    repeat (5) tick();
    @(negedge clk);
    n_cmp++;
    if (bus0.done !== 1'b1 || bus0.wr_en !== 1'b0 || bus0.wr_data !== 32'h8C01_0004 ||
        bus0.wr_addr !== 32'h1) begin
      n_fail++;
      $display("FAIL done_hold: done=%b wr_en=%b wr_data=%h wr_addr=%h required 1 0 8c010004 1",
               bus0.done, bus0.wr_en, bus0.wr_data, bus0.wr_addr);
    end
    tick();
  endtask

  task automatic test_len_errors();
    clear_log();
    pulse_start();
    send_byte(8'h12);
    @(negedge clk);
    n_cmp++;
    if (bus0.error !== 1'b1 || bus0.byte_ready !== 1'b0 || bus0.busy !== 1'b0 || bus0.done !== 1'b0) begin
      n_fail++;
      $display("FAIL len_too_big: error=%b ready=%b busy=%b done=%b required 1 0 0 0",
               bus0.error, bus0.byte_ready, bus0.busy, bus0.done);
    end
    tick();
    pulse_start();
    @(negedge clk);
    n_cmp++;
    if (bus0.error !== 1'b0 || bus0.busy !== 1'b1 || bus0.byte_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_from_err: error=%b busy=%b ready=%b required 0 1 1",
               bus0.error, bus0.busy, bus0.byte_ready);
    end
    tick();
    send_byte(8'h00);
    @(negedge clk);
    n_cmp++;
    if (bus0.error !== 1'b1) begin
      n_fail++;
      $display("FAIL len_zero: error=%b required 1", bus0.error);
    end
    tick();
    pulse_start();
    send_byte(8'h11);
    @(negedge clk);
    n_cmp++;
    if (bus0.error !== 1'b0 || bus0.busy !== 1'b1 || bus0.byte_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL len_max: error=%b busy=%b ready=%b required 0 1 1",
               bus0.error, bus0.busy, bus0.byte_ready);
    end
    n_cmp++;
    if (a0_q.size() !== 0) begin
      n_fail++;
      $display("FAIL len_no_write: writes=%0d required 0", a0_q.size());
    end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Correct checksum would be 01^78^56^34^12 = 09; 08 is sent instead.
  task automatic test_bad_csum();
    clear_log();
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'h08);
    wait_end();
    n_cmp++;
    if (a0_q.size() !== 1 || d0_q[0] !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL bad_csum_write: writes=%0d data=%h required 1 12345678", a0_q.size(), d0_q[0]);
    end
    n_cmp++;
    if (bus0.error !== 1'b1 || bus0.done !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_csum_status: error=%b done=%b required 1 0", bus0.error, bus0.done);
    end
    tick();
  endtask

  task automatic test_stall_toggle();
    logic [7:0] bytes [4];
    bytes[0] = 8'h78; bytes[1] = 8'h56; bytes[2] = 8'h34; bytes[3] = 8'h12;
    clear_log();
    ready_in_wr = 0;
    pulse_start();
    send_byte(8'h01);
    for (int i = 0; i < 4; i++) begin
      send_byte(bytes[i]);
      tick();
      if (i == 1) begin
        repeat (8) tick();
        @(negedge clk);
        n_cmp++;
        if (bus0.busy !== 1'b1 || bus0.byte_ready !== 1'b1 || bus0.wr_en !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_hold: busy=%b ready=%b wr_en=%b required 1 1 0",
                   bus0.busy, bus0.byte_ready, bus0.wr_en);
        end
        tick();
      end
    end
    send_byte(8'h09);
    wait_end();
    n_cmp++;
    if (a0_q.size() !== 1 || d0_q[0] !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL toggle_data: writes=%0d data=%h required 1 12345678", a0_q.size(), d0_q[0]);
    end
    n_cmp++;
    if (bus0.done !== 1'b1 || ready_in_wr !== 0) begin
      n_fail++;
      $display("FAIL toggle_status: done=%b ready_in_write=%0d required 1 0", bus0.done, ready_in_wr);
    end
    tick();
  endtask

  task automatic test_reset_mid_word();
    clear_log();
    pulse_start();
    send_byte(8'h02);
    send_byte(8'hAA);
    send_byte(8'hBB);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus0.busy !== 1'b0 || bus0.byte_ready !== 1'b0 || a0_q.size() !== 0) begin
      n_fail++;
      $display("FAIL abort_state: busy=%b ready=%b writes=%0d required 0 0 0",
               bus0.busy, bus0.byte_ready, a0_q.size());
    end
    tick();
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'h09);
    wait_end();
    n_cmp++;
    if (a0_q.size() !== 1 || a0_q[0] !== 32'h0 || d0_q[0] !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL fresh_write: writes=%0d addr=%h data=%h required 1 0 12345678",
               a0_q.size(), a0_q[0], d0_q[0]);
    end
    n_cmp++;
    if (a1_q.size() !== 1 || a1_q[0] !== 32'h10 || bus0.done !== 1'b1) begin
      n_fail++;
      $display("FAIL fresh_base: writes=%0d addr=%h done=%b required 1 10 1",
               a1_q.size(), a1_q[0], bus0.done);
    end
    tick();
  endtask

  task automatic test_reset_in_write();
    clear_log();
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    n_cmp++;
    if (bus0.wr_en !== 1'b0 || bus0.busy !== 1'b0 || bus0.wr_data !== 32'h0 || a0_q.size() !== 1) begin
      n_fail++;
      $display("FAIL reset_in_write: wr_en=%b busy=%b wr_data=%h writes=%0d required 0 0 0 1",
               bus0.wr_en, bus0.busy, bus0.wr_data, a0_q.size());
    end
    tick();
  endtask

  task automatic test_base_addr();
    clear_log();
    wr_outside = 0;
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h20); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h04);
    pulse_start();
    @(negedge clk);
    n_cmp++;
    if (bus1.busy !== 1'b1 || bus1.byte_ready !== 1'b1 || bus1.done !== 1'b0) begin
      n_fail++;
      $display("FAIL start_ignored: busy=%b ready=%b done=%b required 1 1 0",
               bus1.busy, bus1.byte_ready, bus1.done);
    end
    tick();
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h8C);
    send_byte(8'hAB);
    wait_end();
    n_cmp++;
    if (a1_q.size() !== 2) begin
      n_fail++;
      $display("FAIL base_count: writes=%0d required 2", a1_q.size());
    end else begin
      n_cmp++;
      if (a1_q[0] !== 32'h10 || a1_q[1] !== 32'h11) begin
        n_fail++;
        $display("FAIL base_addr: addr=%h,%h required 10,11", a1_q[0], a1_q[1]);
      end
    end
    n_cmp++;
    if (bus1.done !== 1'b1 || bus1.wr_data !== 32'h8C01_0004 || wr_outside !== 0) begin
      n_fail++;
      $display("FAIL base_done: done=%b wr_data=%h wr_outside=%0d required 1 8c010004 0",
               bus1.done, bus1.wr_data, wr_outside);
    end
    tick();
  endtask

  initial begin
    reset           = 1'b1;
    bus0.start      = 1'b0;
    bus0.byte_valid = 1'b0;
    bus0.byte_data  = 8'h00;
    test_reset();
    test_two_words();
    test_len_errors();
    test_bad_csum();
    test_stall_toggle();
    test_reset_mid_word();
    test_reset_in_write();
    test_base_addr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
